// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one external combinational 4-bit ALU between two
// requesters. Requests are granted round-robin over valid/ready. Operands are
// registered toward the ALU, its outputs are captured one cycle later, and a
// tagged response is returned over valid/ready. Overflowed responses are
// counted in a saturating counter.
module alu_req_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [2:0]        i_req0_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic [2:0]        i_req1_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [2:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_led,
  input  logic              i_alu_carry,
  input  logic              i_alu_overflow,
  input  logic              i_alu_max,
  input  logic              i_alu_equ,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic [3:0]        o_rsp_flags,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_ovf_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_op;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic [3:0]        r_rsp_flags;
  logic [CNT_W-1:0]  r_ovf_cnt;

  // Grant selection: only in IDLE; a tie is broken by the round-robin pointer.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (i_req0_valid && i_req1_valid) begin
        w_gnt0 = ~r_ptr;
        w_gnt1 = r_ptr;
      end else begin
        w_gnt0 = i_req0_valid;
        w_gnt1 = i_req1_valid;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_accept     = w_gnt0 | w_gnt1;
  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and round-robin pointer; the pointer moves only on acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= w_gnt0;
      end
    end
  end

  // Operand registers toward the ALU: loaded at acceptance, otherwise held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a  <= {DATA_W{1'b0}};
      r_alu_b  <= {DATA_W{1'b0}};
      r_alu_op <= 3'd0;
      r_rsp_id <= 1'b0;
    end else if (w_accept) begin
      r_alu_a  <= w_gnt1 ? i_req1_a  : i_req0_a;
      r_alu_b  <= w_gnt1 ? i_req1_b  : i_req0_b;
      r_alu_op <= w_gnt1 ? i_req1_op : i_req0_op;
      r_rsp_id <= w_gnt1;
    end
  end

  // Response channel: capture ALU outputs at the end of EXEC, drop valid on handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= {DATA_W{1'b0}};
      r_rsp_flags  <= 4'd0;
    end else if (r_state == S_EXEC) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= i_alu_led;
      r_rsp_flags  <= {i_alu_carry, i_alu_overflow, i_alu_max, i_alu_equ};
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Saturating count of captured responses whose overflow flag is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_EXEC) && i_alu_overflow && (r_ovf_cnt != CNT_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
    end
  end

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_op     = r_alu_op;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_ovf_cnt    = r_ovf_cnt;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: a sign-magnitude ALU model closes the loop,
// a cycle model of the arbiter predicts handshakes, and a scoreboard queue
// holds the expected response of each accepted operation.
module tb_alu_req_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0_valid, i_req1_valid;
  logic       o_req0_ready, o_req1_ready;
  logic [3:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [2:0] i_req0_op, i_req1_op;
  logic [3:0] o_alu_a, o_alu_b;
  logic [2:0] o_alu_op;
  logic [3:0] i_alu_led;
  logic       i_alu_carry, i_alu_overflow, i_alu_max, i_alu_equ;
  logic       o_rsp_valid, i_rsp_ready, o_rsp_id;
  logic [3:0] o_rsp_result, o_rsp_flags;
  logic       o_busy;
  logic [7:0] o_ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alu_req_arbiter #(.DATA_W(4), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_op(i_req0_op),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_op(i_req1_op),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_led(i_alu_led), .i_alu_carry(i_alu_carry), .i_alu_overflow(i_alu_overflow),
    .i_alu_max(i_alu_max), .i_alu_equ(i_alu_equ),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_flags(o_rsp_flags),
    .o_busy(o_busy), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU, sign-magnitude operands. Returns {carry, overflow, max, equ, result}.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [3:0] r, mag;
    logic       c, v, mx, eq, sb;
    r = 4'd0; c = 1'b0; v = 1'b0; mx = 1'b0; eq = 1'b0; mag = 4'd0; sb = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        sb = b[3] ^ (op == 3'd1);
        if (a[3] == sb) begin
          mag = {1'b0, a[2:0]} + {1'b0, b[2:0]};
          c = mag[3];
          v = mag[3];
          r = {a[3], mag[2:0]};
        end else if (a[2:0] >= b[2:0]) begin
          mag = {1'b0, a[2:0]} - {1'b0, b[2:0]};
          r = {a[3], mag[2:0]};
        end else begin
          mag = {1'b0, b[2:0]} - {1'b0, a[2:0]};
          r = {sb, mag[2:0]};
        end
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin r = (a > b) ? a : b; mx = (a > b); end
      default: begin eq = (a == b); r = 4'd0; end
    endcase
    return {c, v, mx, eq, r};
  endfunction

  logic [7:0] alu_out;
  assign alu_out        = alu_model(o_alu_a, o_alu_b, o_alu_op);
  assign i_alu_led      = alu_out[3:0];
  assign i_alu_equ      = alu_out[4];
  assign i_alu_max      = alu_out[5];
  assign i_alu_overflow = alu_out[6];
  assign i_alu_carry    = alu_out[7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: 0 IDLE, 1 EXEC, 2 RESP. Scoreboard entries are {id, flags, result}.
  int         m_st = 0;
  logic       m_ptr = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic [3:0] m_a = 4'd0, m_b = 4'd0;
  logic [2:0] m_op = 3'd0;
  logic [8:0] sb[$];
  logic       id_log[$];
  int         cyc = 0;
  int         n_rsp = 0;
  bit         chk_spacing = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_hs = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Cycle model and scoreboard: compare at the falling edge, then advance the model.
  always @(negedge i_clk) begin : mon
    logic       e_r0, e_r1;
    logic [8:0] e;
    logic [7:0] res;
    if (!i_rst_n) begin
      m_st = 0; m_ptr = 1'b0; m_cnt = 8'd0; m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
      sb.delete();
      have_prev = 1'b0;
    end else begin
      e_r0 = (m_st == 0) && i_req0_valid && (!i_req1_valid || !m_ptr);
      e_r1 = (m_st == 0) && i_req1_valid && (!i_req0_valid || m_ptr);
      check("ready0", o_req0_ready, e_r0);
      check("ready1", o_req1_ready, e_r1);
      check("busy", o_busy, m_st != 0);
      check("rsp_valid", o_rsp_valid, m_st == 2);
      check("ovf_cnt", o_ovf_cnt, m_cnt);
      if (m_st != 0) begin
        check("alu_a", o_alu_a, m_a);
        check("alu_b", o_alu_b, m_b);
        check("alu_op", o_alu_op, m_op);
      end
      if (m_st == 2) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          check("rsp_id", o_rsp_id, e[8]);
          check("rsp_flags", o_rsp_flags, e[7:4]);
          check("rsp_result", o_rsp_result, e[3:0]);
        end
      end
      case (m_st)
        0: begin
          if (e_r0 || e_r1) begin
            m_a  = e_r1 ? i_req1_a  : i_req0_a;
            m_b  = e_r1 ? i_req1_b  : i_req0_b;
            m_op = e_r1 ? i_req1_op : i_req0_op;
            res  = alu_model(m_a, m_b, m_op);
            sb.push_back({e_r1, res});
            m_ptr = e_r0;
            m_st = 1;
          end
        end
        1: begin
          if (sb.size() != 0) begin
            e = sb[0];
            if (e[6] && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
          end
          m_st = 2;
        end
        default: begin
          if (i_rsp_ready) begin
            if (sb.size() != 0) begin
              e = sb.pop_front();
              id_log.push_back(e[8]);
            end
            n_rsp++;
            if (chk_spacing && have_prev) check("rsp_spacing", cyc - prev_hs, 32'd3);
            prev_hs = cyc;
            have_prev = chk_spacing;
            m_st = 0;
          end
        end
      endcase
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge i_clk); #1;
      if (m_st == 0 && sb.size() == 0 && !i_req0_valid && !i_req1_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", done, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rsp_ready = 1'b1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_rsp_ready = 1'b1;
    i_req0_valid = 1'b0; i_req0_a = 4'd0; i_req0_b = 4'd0; i_req0_op = 3'd0;
    i_req1_valid = 1'b0; i_req1_a = 4'd0; i_req1_b = 4'd0; i_req1_op = 3'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_alu_a", o_alu_a, 4'd0);
    check("rst_alu_op", o_alu_op, 3'd0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_result", o_rsp_result, 4'd0);
    check("rst_rsp_flags", o_rsp_flags, 4'd0);
    check("rst_ovf_cnt", o_ovf_cnt, 8'd0);
    check("rst_busy", o_busy, 1'b0);
    i_rst_n = 1'b1;

    // Single AND from requester 0: latency and contents
    @(posedge i_clk); #1;
    i_req0_valid = 1'b1; i_req0_a = 4'b1100; i_req0_b = 4'b1010; i_req0_op = 3'b011;
    @(negedge i_clk);
    check("t1_ready0", o_req0_ready, 1'b1);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    @(negedge i_clk);
    check("t1_alu_op", o_alu_op, 3'b011);
    @(negedge i_clk);
    check("t1_rsp_valid", o_rsp_valid, 1'b1);
    check("t1_rsp_id", o_rsp_id, 1'b0);
    check("t1_result", o_rsp_result, 4'b1000);
    check("t1_flags", o_rsp_flags, 4'b0000);
    wait_idle();

    // Both requesters valid continuously: alternate grants, 3-cycle spacing
    do_reset();
    id_log.delete();
    chk_spacing = 1'b1;
    i_req0_a = 4'd5; i_req0_b = 4'd3; i_req0_op = 3'd4;
    i_req1_a = 4'd9; i_req1_b = 4'd6; i_req1_op = 3'd5;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    for (int k = 0; k < 40 && id_log.size() < 4; k++) begin
      @(posedge i_clk); #1;
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    wait_idle();
    chk_spacing = 1'b0;
    check("t2_nrsp", id_log.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k < id_log.size()) check("t2_grant_order", id_log[k], k % 2);
    end

    // Backpressure on a requester-1 add
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    i_req1_valid = 1'b1; i_req1_a = 4'd3; i_req1_b = 4'd2; i_req1_op = 3'd0;
    @(negedge i_clk);
    check("t3_ready1", o_req1_ready, 1'b1);
    @(posedge i_clk); #1;
    i_req1_valid = 1'b0;
    i_req0_valid = 1'b1; i_req0_a = 4'd1; i_req0_b = 4'd1; i_req0_op = 3'd6;
    @(negedge i_clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t3_result", o_rsp_result, 4'b0101);
      check("t3_busy", o_busy, 1'b1);
      check("t3_ready0", o_req0_ready, 1'b0);
      check("t3_ready1", o_req1_ready, 1'b0);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("t3_idle_busy", o_busy, 1'b0);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    wait_idle();

    // Overflow counting and saturation
    do_reset();
    i_req0_valid = 1'b1; i_req0_a = 4'd7; i_req0_b = 4'd1; i_req0_op = 3'd0;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("t4_ovf_flag", o_rsp_flags[2], 1'b1);
    check("t4_ovf_result", o_rsp_result, 4'b0000);
    wait_idle();
    check("t4_cnt_one", o_ovf_cnt, 8'd1);
    begin
      int base;
      base = n_rsp;
      i_req0_valid = 1'b1;
      for (int k = 0; k < 1000 && (n_rsp - base) < 259; k++) begin
        @(posedge i_clk); #1;
      end
      i_req0_valid = 1'b0;
      wait_idle();
      check("t4_rsp_count", (n_rsp - base) >= 259, 1'b1);
    end
    check("t4_cnt_sat", o_ovf_cnt, 8'd255);

    // Asynchronous reset in the middle of EXEC
    i_req0_valid = 1'b1; i_req0_a = 4'd1; i_req0_b = 4'd2; i_req0_op = 3'd0;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", o_rsp_valid, 1'b0);
    check("t5_busy", o_busy, 1'b0);
    check("t5_cnt", o_ovf_cnt, 8'd0);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    @(negedge i_clk);
    check("t5_ready0", o_req0_ready, 1'b1);
    check("t5_ready1", o_req1_ready, 1'b0);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    wait_idle();

    // Operand change after acceptance must not affect the result
    i_req0_valid = 1'b1; i_req0_a = 4'd2; i_req0_b = 4'd3; i_req0_op = 3'd0;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0; i_req0_a = 4'hF;
    @(negedge i_clk);
    @(negedge i_clk);
    check("t6_result", o_rsp_result, 4'b0101);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
